ro_meas_sequencer: RTL
======================

Name: ro_meas_sequencer

Overview:
Measurement controller for the ring-oscillator temperature sensor. Takes a decoded command byte from the UART receiver and enables the selected oscillator (inverter or NAND). It then clears and gates the RO edge counter for a fixed reference-clock window, latches the count, and streams the result as bytes to the UART transmitter over a valid/ready handshake. It sits between uart_rx/uart_tx and the oscillator/counter datapath, in the selected clock domain (internal or external clock).

Parameters:
SETTLE_CYCLES, 16, cycles the oscillator runs with the counter held clear before gating (>=1)
GATE_CYCLES, 1024, counter gate window length in clk cycles (>=1)
SYNC_CYCLES, 4, wait after gate closes so the counter value has crossed into clk domain (>=1)
CNT_W, 16, counter/result width (9..16); transmitted zero-extended to 16 bits

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cmd_data  input  8  command byte from UART receiver
cmd_valid  input  1  one-cycle strobe, cmd_data valid
osc_en_inv  output  1  enable inverter ring oscillator
osc_en_nand  output  1  enable NAND ring oscillator
cnt_clear  output  1  synchronous clear to RO counter
cnt_gate  output  1  counter gate window
cnt_value  input  CNT_W  counter value, clk-domain synchronized
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte this cycle
busy  output  1  measurement in progress (state != IDLE)
result  output  CNT_W  last latched count
result_valid  output  1  one-cycle pulse when result updates

Behaviour:
- Reset (async assert, sync release): state IDLE, all outputs 0, result 0.
- Commands: 0x00 = measure inverter RO; 0x01 = measure NAND RO; any other value ignored. cmd_valid while busy is dropped, with no queueing.
- Accepting edge E0: IDLE with cmd_valid=1 and a legal byte. sel <= cmd_data[0]. State -> SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles. Selected osc_en high (the other stays 0), cnt_clear=1, cnt_gate=0.
- GATE: exactly GATE_CYCLES cycles. cnt_clear=0, cnt_gate=1, osc_en held.
- HOLD: exactly SYNC_CYCLES cycles. cnt_gate=0, osc_en held.
- On the HOLD exit edge: result <= cnt_value. State -> TX_HI. result_valid=1 for the first TX_HI cycle only.
- result_valid becomes visible SETTLE_CYCLES+GATE_CYCLES+SYNC_CYCLES cycles after E0.
- osc_en drops to 0 on entering TX_HI; the oscillator is off during transmission.
- TX_HI: tx_valid=1, tx_data = zero-extended result[15:8]. Advance to TX_LO on tx_valid&tx_ready.
- TX_LO: tx_valid=1, tx_data = result[7:0]. On handshake -> IDLE.
- While tx_valid=1 and tx_ready=0, tx_data is stable.
- Back-to-back handshakes need no bubble beyond the state register: one byte per cycle when tx_ready is held high.
- Down-counter: single, shared by SETTLE/GATE/HOLD, width clog2 of the largest parameter. Loaded with N-1 on state entry; transition when it reads 0.
- reset_n low mid-operation clears everything immediately: osc_en, cnt_gate, tx_valid all 0 asynchronously. A partial result is never transmitted.
- cmd_valid in the same cycle as the final TX_LO handshake: ignored, because the state is not IDLE on that edge.

Optional Feature:
RO_MEAS_HEADER_EN
- Defined: a TX_HDR state precedes TX_HI. It sends header byte 0xA4 (inverter) or 0xA5 (NAND), i.e. {7'b1010010, sel}.
- Defined: result_valid pulses on the first TX_HDR cycle instead of the first TX_HI cycle.
- Undefined: two result bytes only, as above.

Test Plan:
Bench uses SETTLE_CYCLES=4, GATE_CYCLES=16, SYNC_CYCLES=4, CNT_W=16.
- Reset: hold reset_n=0 with toggling inputs -> all outputs 0. After release, busy=0 until a command arrives.
- cmd 0x00, cnt_value model = 3x gated edges (48), tx_ready=1:
  - osc_en_inv=1 and osc_en_nand=0 from E0+1.
  - cnt_clear high 4 cycles, then cnt_gate high exactly 16 cycles.
  - result_valid at E0+24 with result=0x0030.
  - bytes 0x00 then 0x30, then busy=0.
- cmd 0x01, cnt_value=0x1234, tx_ready low 10 cycles per byte:
  - only osc_en_nand asserted.
  - tx_valid/tx_data 0x12 held stable until the handshake, then 0x34, then IDLE.
- Illegal and busy commands:
  - cmd 0x02 -> no state change.
  - cmd 0x00 pulsed during GATE of an active run -> ignored; exactly one 2-byte result is sent.
- Reset mid-GATE: pulse reset_n low -> osc_en, cnt_gate, busy go 0 without waiting for a clock edge and no tx bytes are sent. A following cmd 0x00 completes normally.
- With RO_MEAS_HEADER_EN, cmd 0x01, cnt_value=0x00FF -> bytes 0xA5, 0x00, 0xFF. result_valid coincides with the header byte.

Source files
------------

// File: rtl/ro_meas_sequencer.sv
// ro_meas_sequencer: ring-oscillator measurement controller.
// Accepts a command byte (0x00 inverter RO, 0x01 NAND RO) and enables the
// selected oscillator. It then clears and gates the RO counter for a fixed
// window, waits for the count to settle in this clock domain, latches it,
// and streams it MSB first over a valid/ready byte interface.
// Optional build macro: RO_MEAS_HEADER_EN adds a header byte
// {7'b1010010, sel} ahead of the two result bytes.
module ro_meas_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int SYNC_CYCLES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    output logic             osc_en_inv,
    output logic             osc_en_nand,
    output logic             cnt_clear,
    output logic             cnt_gate,
    input  logic [CNT_W-1:0] cnt_value,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid
);

    // One down-counter serves all three timed phases, so it is sized for the longest.
    localparam int MAX_SG = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int MAX_P  = (MAX_SG > SYNC_CYCLES) ? MAX_SG : SYNC_CYCLES;
    localparam int TMR_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SYNC_LOAD   = TMR_W'(SYNC_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        HOLD,
        TX_HDR,
        TX_HI,
        TX_LO
    } state_t;

    state_t           state;
    logic             sel;
    logic [TMR_W-1:0] tmr;
    logic             cmd_legal;

    // High byte of the result, zero-extended to 16 bits when CNT_W < 16.
    function automatic logic [7:0] hi_byte(input logic [CNT_W-1:0] v);
        logic [15:0] w;
        w = 16'(v);
        return w[15:8];
    endfunction

    // Low byte of the result.
    function automatic logic [7:0] lo_byte(input logic [CNT_W-1:0] v);
        logic [15:0] w;
        w = 16'(v);
        return w[7:0];
    endfunction

    // Only 0x00 and 0x01 start a measurement; everything else is ignored.
    assign cmd_legal = (cmd_data[7:1] == 7'd0);

    // Sequencer: state, phase timer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sel          <= 1'b0;
            tmr          <= '0;
            osc_en_inv   <= 1'b0;
            osc_en_nand  <= 1'b0;
            cnt_clear    <= 1'b0;
            cnt_gate     <= 1'b0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_legal) begin
                        sel         <= cmd_data[0];
                        state       <= SETTLE;
                        tmr         <= SETTLE_LOAD;
                        osc_en_inv  <= ~cmd_data[0];
                        osc_en_nand <= cmd_data[0];
                        cnt_clear   <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (tmr == '0) begin
                        state     <= GATE;
                        tmr       <= GATE_LOAD;
                        cnt_clear <= 1'b0;
                        cnt_gate  <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                GATE: begin
                    if (tmr == '0) begin
                        state    <= HOLD;
                        tmr      <= SYNC_LOAD;
                        cnt_gate <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                HOLD: begin
                    if (tmr == '0) begin
                        // Count has crossed into this domain: latch it and shut the oscillator off.
                        result       <= cnt_value;
                        result_valid <= 1'b1;
                        osc_en_inv   <= 1'b0;
                        osc_en_nand  <= 1'b0;
                        tx_valid     <= 1'b1;
`ifdef RO_MEAS_HEADER_EN
                        state   <= TX_HDR;
                        tx_data <= {7'b1010010, sel};
`else
                        state   <= TX_HI;
                        tx_data <= hi_byte(cnt_value);
`endif
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                TX_HDR: begin
                    if (tx_ready) begin
                        state   <= TX_HI;
                        tx_data <= hi_byte(result);
                    end
                end
                TX_HI: begin
                    if (tx_ready) begin
                        state   <= TX_LO;
                        tx_data <= lo_byte(result);
                    end
                end
                TX_LO: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
